vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 100 ++++++++++
 tb/tb_vram_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display scanout has absolute priority, a
// held-request writer is granted the port during blanking, one write per clock.
module vram_arbiter #(
    parameter int H_DISPLAY = 640,
    parameter int V_DISPLAY = 480,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hDisplay,
    input  logic              vDisplay,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_DISPLAY * V_DISPLAY - 1);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE} state_t;

    state_t            state;
    state_t            state_next;
    logic              active;
    logic [ADDR_W-1:0] scan_addr;
    logic              rd_pending;

    assign active = ~hDisplay & ~vDisplay;

    // NOTE: state_next gets its default before any branch so no latch is inferred.
    always_comb begin
        state_next = IDLE;
        if (active)
            state_next = SCAN;
        else if (wr_req)
            state_next = WRITE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // RAM port outputs are registered off the state being entered, so the
    // port reflects the state for the whole cycle after the deciding edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            wr_gnt    <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            wr_gnt <= 1'b0;
            case (state_next)
                SCAN: ram_addr <= scan_addr;
                WRITE: begin
                    ram_addr  <= wr_addr;
                    ram_wdata <= wr_data;
                    ram_we    <= 1'b1;
                    wr_gnt    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            scan_addr <= '0;
        else if (vDisplay)
            scan_addr <= '0;
        else if (state_next == SCAN)
            scan_addr <= (scan_addr == LAST_ADDR) ? '0 : scan_addr + 1'b1;
    end

    // The RAM returns data one cycle after the SCAN address cycle; capture it
    // on the following edge, giving two clocks from the Active sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
        end else begin
            rd_pending <= (state == SCAN);
            pix_valid  <= rd_pending;
            pix_data   <= rd_pending ? ram_rdata : '0;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter: synchronous RAM model plus an
// edge-by-edge reference of port ownership, scan addresses and pixel stream.
module tb_vram_arbiter;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int N  = H * V;
    localparam int MEM_SIZE = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hDisplay, vDisplay;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic          preload;

    vram_arbiter #(.H_DISPLAY(H), .V_DISPLAY(V), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .hDisplay(hDisplay), .vDisplay(vDisplay),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .pix_data(pix_data), .pix_valid(pix_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pattern(int i);
        return DW'(i * 29 + 7);
    endfunction

    // Synchronous single-port RAM: read data valid the cycle after the address.
    logic [DW-1:0] mem [MEM_SIZE];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEM_SIZE; i++) mem[i] <= pattern(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [DW-1:0] ref_mem [MEM_SIZE];
    int            cnt;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic          exp_we, exp_gnt, exp_pv;
    logic [DW-1:0] exp_pd;
    logic          hist_valid [2];
    logic [DW-1:0] hist_data [2];
    logic          pend_we;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    logic          granted;
    logic          auto_writer;

    task automatic model_reset();
        cnt       = 0;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_we    = 1'b0;
        exp_gnt   = 1'b0;
        exp_pv    = 1'b0;
        exp_pd    = '0;
        pend_we   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hist_valid[i] = 1'b0;
            hist_data[i]  = '0;
        end
    endtask

    // Predict what the upcoming edge produces from the currently driven inputs.
    task automatic model_edge();
        if (pend_we) ref_mem[pend_addr] = pend_data;
        pend_we = 1'b0;
        exp_pv = hist_valid[1];
        exp_pd = hist_valid[1] ? hist_data[1] : '0;
        hist_valid[1] = hist_valid[0];
        hist_data[1]  = hist_data[0];
        hist_valid[0] = 1'b0;
        hist_data[0]  = '0;
        exp_we  = 1'b0;
        exp_gnt = 1'b0;
        granted = 1'b0;
        if (!hDisplay && !vDisplay) begin
            exp_addr      = AW'(cnt);
            hist_valid[0] = 1'b1;
            hist_data[0]  = ref_mem[cnt];
            cnt           = (cnt + 1) % N;
        end else if (wr_req) begin
            exp_addr  = wr_addr;
            exp_wdata = wr_data;
            exp_we    = 1'b1;
            exp_gnt   = 1'b1;
            pend_we   = 1'b1;
            pend_addr = wr_addr;
            pend_data = wr_data;
            granted   = 1'b1;
        end
        if (vDisplay) cnt = 0;
    endtask

    task automatic new_request();
        wr_req  = 1'b1;
        wr_addr = AW'($urandom_range(0, MEM_SIZE - 1));
        wr_data = DW'($urandom);
    endtask

    task automatic check_outputs();
        check("ram_we",    ram_we,    exp_we);
        check("wr_gnt",    wr_gnt,    exp_gnt);
        check("ram_addr",  ram_addr,  exp_addr);
        check("ram_wdata", ram_wdata, exp_wdata);
        check("pix_valid", pix_valid, exp_pv);
        check("pix_data",  pix_data,  exp_pd);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
        if (granted) begin
            if (auto_writer && $urandom_range(0, 9) < 7) new_request();
            else wr_req = 1'b0;
        end else if (auto_writer && !wr_req && $urandom_range(0, 9) < 3) begin
            new_request();
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_we"},   ram_we,    0);
        check({tag, "_gnt"},  wr_gnt,    0);
        check({tag, "_addr"}, ram_addr,  0);
        check({tag, "_wd"},   ram_wdata, 0);
        check({tag, "_pv"},   pix_valid, 0);
        check({tag, "_pd"},   pix_data,  0);
    endtask

    // Called one time unit after an edge: reset lands mid-cycle.
    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        model_reset();
        @(posedge clk);
        #1 check_all_zero("rst_hold");
        #3 rst_n = 1'b1;
    endtask

    task automatic run_frame(int hblank, int vblank, bit do_reset);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                hDisplay = 1'b0;
                vDisplay = 1'b0;
                step();
                if (do_reset && y == 1 && x == 3) reset_pulse();
            end
            for (int b = 0; b < hblank; b++) begin
                hDisplay = 1'b1;
                vDisplay = 1'b0;
                step();
            end
        end
        for (int b = 0; b < vblank; b++) begin
            hDisplay = 1'($urandom_range(0, 1));
            vDisplay = 1'b1;
            step();
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        hDisplay    = 1'b1;
        vDisplay    = 1'b1;
        wr_req      = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        auto_writer = 1'b0;
        preload     = 1'b1;
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = pattern(i);
        model_reset();
        repeat (2) @(posedge clk);
        preload = 1'b0;
        #1 check_all_zero("reset");

        // Blanking write to 0x10 / 0xA5 right after reset release.
        #3 rst_n = 1'b1;
        wr_req  = 1'b1;
        wr_addr = AW'(6'h10);
        wr_data = DW'(8'hA5);
        step();
        check("blank_wr_we",   ram_we,    1);
        check("blank_wr_addr", ram_addr,  'h10);
        check("blank_wr_data", ram_wdata, 'hA5);
        check("blank_wr_gnt",  wr_gnt,    1);
        repeat (3) step();

        // Request rises together with the first Active edge and is held
        // through the line; it must wait for blanking.
        wr_req  = 1'b1;
        wr_addr = AW'(5);
        wr_data = DW'(8'h3C);
        run_frame(2, 3, 1'b0);
        run_frame(1, 2, 1'b0);

        auto_writer = 1'b1;
        for (int f = 0; f < 6; f++)
            run_frame($urandom_range(1, 3), $urandom_range(1, 5), 1'b0);

        // Reset mid-line while writes are streaming, then full frames again.
        run_frame(2, 2, 1'b1);
        for (int f = 0; f < 4; f++)
            run_frame($urandom_range(1, 3), $urandom_range(1, 4), 1'b0);

        // Long Active stretches without vertical blanking exercise the wrap.
        for (int k = 0; k < 400; k++) begin
            hDisplay = ($urandom_range(0, 9) == 0);
            vDisplay = ($urandom_range(0, 49) == 0);
            step();
        end

        // Fully random timing.
        for (int k = 0; k < 600; k++) begin
            hDisplay = 1'($urandom_range(0, 1));
            vDisplay = ($urandom_range(0, 5) == 0);
            step();
        end

        run_frame(2, 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
